// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state type, counter widths and a width helper for the
// PLL lock sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABILIZE,
      RUN,
      FAULT
   } pll_seq_state_e;

   localparam int unsigned LOSS_CNT_W  = 8;
   localparam int unsigned RETRY_CNT_W = 2;

   // Width of a counter that must reach (max(a,b,c) - 1).
   function automatic int unsigned seq_cnt_width(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input; both stages clear on reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the rPLL reset pin, qualifies lock and releases
// the downstream synchronous reset once lock is stable. Re-sequences on lock
// loss with bounded retries and a latched fault.
// Optional feature: define PLL_SEQ_LOSS_COUNT_EN to build the lock-loss
// counter; otherwise loss_cnt is tied to zero.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RESET_HOLD_CYCLES   = 27,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 27000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 270,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic                   clkin,
   input  logic                   reset,
   input  logic                   pll_lock,
   input  logic                   relock_req,
   output logic                   pll_reset,
   output logic                   sys_rst,
   output logic                   locked,
   output logic                   fault,
   output logic [RETRY_CNT_W-1:0] retry_cnt,
   output logic [LOSS_CNT_W-1:0]  loss_cnt
);

   localparam int unsigned CNT_W =
      seq_cnt_width(RESET_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_CNT_W-1:0] RETRY_MAX = RETRY_CNT_W'(MAX_RETRIES);

   logic lock_s;

   pll_seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [RETRY_CNT_W-1:0] retry_q, retry_d;
   logic                   pll_reset_q, pll_reset_d;
   logic                   sys_rst_q, sys_rst_d;
   logic                   locked_q, locked_d;
   logic                   fault_q, fault_d;

   sync_2ff u_lock_sync (
      .clk_i (clkin),
      .rst_i (reset),
      .d_i   (pll_lock),
      .q_o   (lock_s)
   );

   // Next-state, shared counter, retry count and registered-output decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;

      unique case (state_q)
         RESET_PLL: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HOLD_LAST) begin
               state_d = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            cnt_d = cnt_q + 1'b1;
            if (lock_s) begin
               state_d = STABILIZE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               if (retry_q == RETRY_MAX) begin
                  state_d = FAULT;
               end else begin
                  retry_d = retry_q + 1'b1;
                  state_d = RESET_PLL;
               end
            end
         end
         STABILIZE: begin
            cnt_d = cnt_q + 1'b1;
            if (!lock_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = RUN;
               retry_d = '0;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = RESET_PLL;
            end
         end
         FAULT: begin
         end
         default: begin
            state_d = RESET_PLL;
         end
      endcase

      if (relock_req) begin
         state_d = RESET_PLL;
         retry_d = '0;
      end

      // relock_req in RESET_PLL keeps the state but must restart the hold.
      if ((state_d != state_q) || relock_req) begin
         cnt_d = '0;
      end

      pll_reset_d = (state_d == RESET_PLL) || (state_d == FAULT);
      sys_rst_d   = (state_d != RUN);
      locked_d    = (state_d == RUN);
      fault_d     = (state_d == FAULT);
   end

   // State, counters and outputs all update on the same edge.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q     <= RESET_PLL;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_reset_q <= 1'b1;
         sys_rst_q   <= 1'b1;
         locked_q    <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_reset_q <= pll_reset_d;
         sys_rst_q   <= sys_rst_d;
         locked_q    <= locked_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_reset = pll_reset_q;
   assign sys_rst   = sys_rst_q;
   assign locked    = locked_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
   logic                  loss_evt;
   logic [LOSS_CNT_W-1:0] loss_q, loss_d;

   // A loss is counted even when relock_req wins the same cycle.
   assign loss_evt = (state_q == RUN) && !lock_s;

   // Saturating lock-loss count.
   always_comb begin
      loss_d = loss_q;
      if (loss_evt && (loss_q != '1)) begin
         loss_d = loss_q + 1'b1;
      end
   end

   // Loss counter register.
   always_ff @(posedge clkin) begin
      if (reset) begin
         loss_q <= '0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign loss_cnt = loss_q;
`else
   assign loss_cnt = '0;
`endif

endmodule
